// File: rtl/spdif_encode.sv
// spdif_encode: S/PDIF (IEC 60958 consumer) biphase-mark transmitter with a one-entry sample buffer
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   sample_left    24-bit left sample (two's complement)
//   sample_right   24-bit right sample (two's complement)
//   sample_valid   sample pair offered
//   sample_ready   buffer empty; transfer on sample_valid && sample_ready
//   spdif          registered BMC line output
//   underrun       one-cycle pulse when a frame starts with an empty buffer
// Optional feature: define SPDIF_ENCODE_CSTAT_EN to send the consumer channel-status block on C.
module spdif_encode #(
  parameter int CLK_IN_FREQ   = 38400000,
  parameter int HALF_BIT_FREQ = 6144000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sample_left,
  input  logic [23:0] sample_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        spdif,
  output logic        underrun
);
  localparam logic [27:0] CLK_F  = 28'(CLK_IN_FREQ);
  localparam logic [27:0] HALF_F = 28'(HALF_BIT_FREQ);
  logic [26:0] acc_q, acc_d;
  logic [27:0] acc_sum;
  logic        tick, frame_start, xfer, c_bit, data_bit;
  logic [6:0]  slot_q, slot_d;
  logic [7:0]  frame_q, frame_d;
  logic        full_q, full_d;
  logic [23:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d, latch_r_q, latch_r_d;
  logic [27:0] pay_q, pay_d;
  logic        spdif_q, spdif_d, start_q, start_d;
  logic [23:0] audio;
  logic [7:0]  pre;
  logic [5:0]  h, h_data;
  logic [31:0] pay_ext;
  assign acc_sum      = {1'b0, acc_q} + HALF_F;
  assign tick         = acc_sum >= CLK_F;
  assign frame_start  = tick && slot_q == 7'd0;
  assign xfer         = sample_valid && !full_q;
  assign sample_ready = !full_q;
  assign spdif        = spdif_q;
  assign underrun     = frame_start && !full_q;
  assign h            = slot_q[5:0];
  // data half-bits start at 8; two half-bits per payload bit, LSB first
  assign h_data       = h - 6'd8;
  assign pay_ext      = {4'd0, pay_q};
  assign data_bit     = pay_ext[h_data[5:1]];
`ifdef SPDIF_ENCODE_CSTAT_EN
  localparam logic [191:0] CSTAT = (192'd1 << 2) | (192'd1 << 25);
  assign c_bit = CSTAT[frame_q];
`else
  assign c_bit = 1'b0;
`endif
  // left audio is taken straight from the buffer at frame start; right waits in the frame latch
  assign audio = slot_q[6] ? latch_r_q : (full_q ? buf_l_q : 24'd0);
  assign pre   = slot_q[6] ? 8'b11100100 : (frame_q == 8'd0 ? 8'b11101000 : 8'b11100010);
  always_comb begin
    acc_d     = tick ? 27'(acc_sum - CLK_F) : acc_sum[26:0];
    slot_d    = tick ? slot_q + 7'd1 : slot_q;
    frame_d   = (tick && slot_q == 7'd127) ? (frame_q == 8'd191 ? 8'd0 : frame_q + 8'd1) : frame_q;
    full_d    = xfer ? 1'b1 : (frame_start ? 1'b0 : full_q);
    buf_l_d   = xfer ? sample_left : buf_l_q;
    buf_r_d   = xfer ? sample_right : buf_r_q;
    latch_r_d = frame_start ? (full_q ? buf_r_q : 24'd0) : latch_r_q;
    pay_d     = (tick && h == 6'd0) ? {^{c_bit, audio}, c_bit, 2'b00, audio} : pay_q;
    start_d   = (tick && h == 6'd0) ? spdif_q : start_q;
    // preamble levels are relative to the level the subframe starts at
    spdif_d   = !tick ? spdif_q :
                h == 6'd0 ? ~spdif_q :
                h < 6'd8 ? pre[~h[2:0]] ^ start_q :
                !h[0] ? ~spdif_q : spdif_q ^ data_bit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      slot_q    <= '0;
      frame_q   <= '0;
      full_q    <= 1'b0;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
      latch_r_q <= '0;
      pay_q     <= '0;
      spdif_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      slot_q    <= slot_d;
      frame_q   <= frame_d;
      full_q    <= full_d;
      buf_l_q   <= buf_l_d;
      buf_r_q   <= buf_r_d;
      latch_r_q <= latch_r_d;
      pay_q     <= pay_d;
      spdif_q   <= spdif_d;
      start_q   <= start_d;
    end
  end
endmodule

// File: tb/tb_spdif_encode.sv
// tb_spdif_encode: scoreboard bench decoding the BMC line of spdif_encode
module tb_spdif_encode;
  localparam int CF = 38400000;
  localparam int HF = 6144000;
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        ur;
  } exp_t;
  logic clk = 0, rst_n = 0, sample_valid = 0, sample_ready, spdif, underrun;
  logic [23:0] sample_left = 0, sample_right = 0;
  int checks = 0, errors = 0;
  exp_t sb[$];
  exp_t cur;
  bit cur_ok = 0;
  int bacc = 0, bslot = 0, bframe = 0, fs_count = 0, gap = 0, p_slot = 0, p_frame = 0;
  bit pend = 0, lvl = 0, start_lvl = 0, sf_ok = 0;
  bit [63:0] hb;
  int n;

  spdif_encode dut (
    .clk(clk), .rst_n(rst_n), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .spdif(spdif), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic decode(input bit right, input int f);
    logic [7:0] pre, pexp;
    logic [27:0] d;
    bit bad, prev, cexp;
    for (int i = 0; i < 8; i++) pre[7-i] = hb[i] ^ start_lvl;
    pexp = right ? 8'b11100100 : (f == 0 ? 8'b11101000 : 8'b11100010);
    chk(right ? "preamble_y" : "preamble_xz", 32'(pre), 32'(pexp));
    prev = hb[7];
    bad = 0;
    for (int k = 0; k < 28; k++) begin
      if (hb[8+2*k] == prev) bad = 1;
      d[k] = hb[8+2*k] ^ hb[9+2*k];
      prev = hb[9+2*k];
    end
`ifdef SPDIF_ENCODE_CSTAT_EN
    cexp = (f == 2 || f == 25);
`else
    cexp = 0;
`endif
    chk("bmc_transitions", 32'(bad), 32'(0));
    chk("parity_even", 32'(^d), 32'(0));
    chk("end_level", 32'(hb[63]), 32'(start_lvl));
    chk("c_u_v", 32'(d[26:24]), 32'({cexp, 2'b00}));
    if (cur_ok) chk(right ? "audio_right" : "audio_left", 32'(d[23:0]), 32'(right ? cur.r : cur.l));
  endtask

  // monitor: own half-bit timing model, samples the line after each tick edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_spdif", 32'(spdif), 32'(0));
      chk("reset_ready", 32'(sample_ready), 32'(1));
      bacc = 0; bslot = 0; bframe = 0; fs_count = 0; gap = 0;
      lvl = 0; sf_ok = 0; cur_ok = 0;
    end else if (pend) begin
      if (p_slot % 64 == 0) begin
        start_lvl = lvl;
        sf_ok = 1;
      end
      hb[p_slot % 64] = spdif;
      lvl = spdif;
      if (p_slot % 64 == 63 && sf_ok) decode(p_slot >= 64, p_frame);
    end else chk("spdif_hold", 32'(spdif), 32'(lvl));
    pend = bacc + HF >= CF;
    gap++;
    if (pend) begin
      chk("tick_gap", 32'(gap == 6 || gap == 7), 32'(1));
      gap = 0;
      p_slot = bslot;
      p_frame = bframe;
      bacc = bacc + HF - CF;
      if (bslot == 0) begin
        fs_count++;
        if (sb.size() == 0) begin
          checks++; errors++; cur_ok = 0;
          $display("FAIL scoreboard_empty actual=0 expected=1 entries t=%0t", $time);
        end else begin
          cur = sb.pop_front();
          cur_ok = 1;
          chk("underrun_frame_start", 32'(underrun), 32'(cur.ur));
        end
      end else chk("underrun_idle", 32'(underrun), 32'(0));
      if (bslot == 127) bframe = (bframe + 1) % 192;
      bslot = (bslot + 1) % 128;
    end else begin
      bacc = bacc + HF;
      chk("underrun_idle", 32'(underrun), 32'(0));
    end
  end

  task automatic wait_fs(input int target);
    int g = 0;
    @(posedge clk);
    while (fs_count < target && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (fs_count < target) begin
      checks++; errors++;
      $display("FAIL frame_wait actual=%0d expected=%0d", fs_count, target);
    end
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    #1;
    chk("ready_at_frame_start", 32'(sample_ready), 32'(1));
    sample_left = l;
    sample_right = r;
    sample_valid = 1;
    @(posedge clk);
    #1 sample_valid = 0;
    chk("ready_after_transfer", 32'(sample_ready), 32'(0));
  endtask

  initial begin
    sb.push_back('{24'd0, 24'd0, 1'b1});
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    n = 1;
    for (int i = 0; i < 6; i++) begin
      wait_fs(n);
      if (i == 0) sb.push_back('{24'd0, 24'd0, 1'b1});
      else if (i == 1) begin
        sb.push_back('{24'h000001, 24'h800000, 1'b0});
        offer(24'h000001, 24'h800000);
      end else if (i == 2) begin
        sb.push_back('{24'h7FFFFF, 24'hA5A5A5, 1'b0});
        offer(24'h7FFFFF, 24'hA5A5A5);
      end else if (i == 3) begin
        // transfer lands exactly on the next frame-start edge with an empty buffer
        sb.push_back('{24'd0, 24'd0, 1'b1});
        @(negedge clk);
        repeat (799) @(negedge clk);
        #1;
        sample_left = 24'h123456;
        sample_right = 24'hFEDCBA;
        sample_valid = 1;
      end else if (i == 4) begin
        #1 sample_valid = 0;
        chk("ready_after_edge_transfer", 32'(sample_ready), 32'(0));
        sb.push_back('{24'h123456, 24'hFEDCBA, 1'b0});
      end else begin
        sb.push_back('{24'h0F0F0F, 24'h00FF00, 1'b0});
        offer(24'h0F0F0F, 24'h00FF00);
        repeat (248) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("async_reset_spdif", 32'(spdif), 32'(0));
        chk("async_reset_ready", 32'(sample_ready), 32'(1));
        chk("async_reset_underrun", 32'(underrun), 32'(0));
        sb.delete();
        sb.push_back('{24'd0, 24'd0, 1'b1});
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
      end
      n++;
    end
    n = 1;
    for (int i = 0; i < 29; i++) begin
      wait_fs(n);
      if (i < 27) begin
        logic [23:0] l;
        l = 24'(i * 24'h010203 + 24'h000001);
        sb.push_back('{l, ~l, 1'b0});
        offer(l, ~l);
      end else sb.push_back('{24'd0, 24'd0, 1'b1});
      n++;
    end
    wait_fs(n);
    repeat (797) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
